// File: rtl/audio_pkg.sv
// Shared types and sizing for the audio frame loader slice.
package audio_pkg;

    localparam int unsigned SAMPLE_W         = 16;
    localparam int unsigned SAMPLES_PER_LINE = 32;
    localparam int unsigned LINES            = 64;
    localparam int unsigned BUS_W            = SAMPLE_W * SAMPLES_PER_LINE;
    localparam int unsigned SLOT_W           = $clog2(SAMPLES_PER_LINE);
    localparam int unsigned IDX_W            = $clog2(LINES);

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic [BUS_W-1:0]           line_t;

    typedef enum logic [2:0] {
        FILL,
        WRITE,
        START,
        WAIT_DONE,
        READ,
        DRAIN
    } loader_state_e;

endpackage

// File: rtl/audio_frame_loader_line_serdes.sv
// One-line serialiser/deserialiser shared by the fill and drain paths.
// Serial-in pushes new samples in at the top so that, after a full line,
// the first sample sits at the LSBs; serial-out shifts the line down so
// the current output sample is always at the LSBs.
module line_serdes
    import audio_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              shift_in,
    input  logic              load,
    input  logic              shift_out,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic [BUS_W-1:0]  line_in,
    output logic [BUS_W-1:0]  line_out,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic [SLOT_W-1:0] slot_cnt
);

    line_t             line_q, line_d;
    logic [SLOT_W-1:0] slot_q, slot_d;

    // Select the next line contents and slot position for the active mode.
    always_comb begin
        line_d = line_q;
        slot_d = slot_q;
        if (clr) begin
            line_d = '0;
            slot_d = '0;
        end else if (load) begin
            line_d = line_in;
            slot_d = '0;
        end else if (shift_in) begin
            line_d = {sample_in, line_q[BUS_W-1:SAMPLE_W]};
            slot_d = slot_q + SLOT_W'(1);
        end else if (shift_out) begin
            line_d = {{SAMPLE_W{1'b0}}, line_q[BUS_W-1:SAMPLE_W]};
            slot_d = slot_q + SLOT_W'(1);
        end
    end

    // Line register and slot counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            line_q <= '0;
            slot_q <= '0;
        end else begin
            line_q <= line_d;
            slot_q <= slot_d;
        end
    end

    assign line_out   = line_q;
    assign sample_out = line_q[SAMPLE_W-1:0];
    assign slot_cnt   = slot_q;

endmodule

// File: rtl/audio_frame_loader.sv
// Streaming front/back end for AudioProcessor: packs input samples into
// lines, writes a full frame, starts processing, then streams the
// processed frame back out sample by sample.
module audio_frame_loader
    import audio_pkg::*;
#(
    parameter int unsigned RD_LATENCY   = 1,
    parameter int unsigned DONE_TIMEOUT = 16384
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [SAMPLE_W-1:0]  in_sample,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [SAMPLE_W-1:0]  out_sample,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 ap_data_wr_en,
    output logic [IDX_W-1:0]     ap_input_index,
    output logic [BUS_W-1:0]     ap_data_in,
    output logic                 ap_start,
    input  logic                 ap_done,
    output logic [IDX_W-1:0]     ap_output_index,
    input  logic [BUS_W-1:0]     ap_data_out,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam int unsigned TMO_W = (DONE_TIMEOUT < 2) ? 1 : $clog2(DONE_TIMEOUT);
    localparam int unsigned RD_W  = (RD_LATENCY < 1) ? 1 : $clog2(RD_LATENCY + 1);

    loader_state_e     state_q, state_d;
    logic [IDX_W-1:0]  line_cnt_q, line_cnt_d;
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic [RD_W-1:0]   rd_cnt_q, rd_cnt_d;
    logic              timeout_err_q, timeout_err_d;

    logic              sd_clr;
    logic              sd_shift_in;
    logic              sd_load;
    logic              sd_shift_out;
    line_t             sd_line;
    logic [SAMPLE_W-1:0] sd_sample;
    logic [SLOT_W-1:0] sd_slot;

    line_serdes u_serdes (
        .clk        (clk),
        .rst        (rst),
        .clr        (sd_clr),
        .shift_in   (sd_shift_in),
        .load       (sd_load),
        .shift_out  (sd_shift_out),
        .sample_in  (in_sample),
        .line_in    (ap_data_out),
        .line_out   (sd_line),
        .sample_out (sd_sample),
        .slot_cnt   (sd_slot)
    );

    // Next-state logic and all stream / AudioProcessor outputs.
    always_comb begin
        state_d         = state_q;
        line_cnt_d      = line_cnt_q;
        tmo_cnt_d       = tmo_cnt_q;
        rd_cnt_d        = rd_cnt_q;
        timeout_err_d   = timeout_err_q;
        sd_clr          = 1'b0;
        sd_shift_in     = 1'b0;
        sd_load         = 1'b0;
        sd_shift_out    = 1'b0;
        in_ready        = 1'b0;
        out_valid       = 1'b0;
        out_last        = 1'b0;
        out_sample      = '0;
        ap_data_wr_en   = 1'b0;
        ap_input_index  = '0;
        ap_data_in      = '0;
        ap_start        = 1'b0;
        ap_output_index = '0;
        busy            = 1'b1;

        case (state_q)
            FILL: begin
                busy     = 1'b0;
                in_ready = ~rst;
                if (in_valid && in_ready) begin
                    sd_shift_in = 1'b1;
                    if (sd_slot == SLOT_W'(SAMPLES_PER_LINE - 1)) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                ap_data_wr_en  = 1'b1;
                ap_input_index = line_cnt_q;
                ap_data_in     = sd_line;
                line_cnt_d     = line_cnt_q + IDX_W'(1);
                state_d        = (line_cnt_q == IDX_W'(LINES - 1)) ? START : FILL;
            end
            START: begin
                ap_start  = 1'b1;
                tmo_cnt_d = TMO_W'(1);
                state_d   = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (ap_done) begin
                    line_cnt_d = '0;
                    rd_cnt_d   = '0;
                    state_d    = READ;
                end else if (tmo_cnt_q == TMO_W'(DONE_TIMEOUT - 1)) begin
                    timeout_err_d = 1'b1;
                    line_cnt_d    = '0;
                    sd_clr        = 1'b1;
                    state_d       = FILL;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            READ: begin
                ap_output_index = line_cnt_q;
                if (rd_cnt_q == RD_W'(RD_LATENCY)) begin
                    sd_load = 1'b1;
                    state_d = DRAIN;
                end else begin
                    rd_cnt_d = rd_cnt_q + RD_W'(1);
                end
            end
            DRAIN: begin
                ap_output_index = line_cnt_q;
                out_valid       = 1'b1;
                out_sample      = sd_sample;
                out_last        = (sd_slot == SLOT_W'(SAMPLES_PER_LINE - 1)) &&
                                  (line_cnt_q == IDX_W'(LINES - 1));
                if (out_ready) begin
                    sd_shift_out = 1'b1;
                    if (sd_slot == SLOT_W'(SAMPLES_PER_LINE - 1)) begin
                        if (line_cnt_q == IDX_W'(LINES - 1)) begin
                            line_cnt_d = '0;
                            state_d    = FILL;
                        end else begin
                            line_cnt_d = line_cnt_q + IDX_W'(1);
                            rd_cnt_d   = '0;
                            state_d    = READ;
                        end
                    end
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // State, counters and the sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FILL;
            line_cnt_q    <= '0;
            tmo_cnt_q     <= '0;
            rd_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            line_cnt_q    <= line_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
            rd_cnt_q      <= rd_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_audio_frame_loader.sv
// Directed/randomised bench for audio_frame_loader with an AudioProcessor
// model that returns the bitwise inverse of each written line.
module tb_audio_frame_loader;
    import audio_pkg::*;

    localparam int T_OUT = 16384;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [15:0]  in_sample = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [15:0]  out_sample;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic         out_last;
    logic         ap_data_wr_en;
    logic [5:0]   ap_input_index;
    logic [511:0] ap_data_in;
    logic         ap_start;
    logic         ap_done = 1'b0;
    logic [5:0]   ap_output_index;
    logic [511:0] ap_data_out = '0;
    logic         busy;
    logic         timeout_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [15:0]  stim [2048];
    logic [511:0] mem [64];
    int           wr_idx_q[$];
    int           wr_cyc_q[$];
    logic [511:0] wr_dat_q[$];
    int           start_cyc_q[$];

    audio_frame_loader #(.RD_LATENCY(1), .DONE_TIMEOUT(16384)) dut (
        .clk             (clk),
        .rst             (rst),
        .in_sample       (in_sample),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .out_sample      (out_sample),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_last        (out_last),
        .ap_data_wr_en   (ap_data_wr_en),
        .ap_input_index  (ap_input_index),
        .ap_data_in      (ap_data_in),
        .ap_start        (ap_start),
        .ap_done         (ap_done),
        .ap_output_index (ap_output_index),
        .ap_data_out     (ap_data_out),
        .busy            (busy),
        .timeout_err     (timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // AudioProcessor model: line store, registered read of the inverted line.
    always @(posedge clk) begin
        if (ap_data_wr_en) mem[ap_input_index] <= ap_data_in;
        ap_data_out <= ~mem[ap_output_index];
    end

    // Record write strobes and start pulses with their cycle stamps.
    always @(negedge clk) begin
        if (ap_data_wr_en) begin
            wr_idx_q.push_back(int'(ap_input_index));
            wr_cyc_q.push_back(cyc);
            wr_dat_q.push_back(ap_data_in);
        end
        if (ap_start) start_cyc_q.push_back(cyc);
    end

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        wr_idx_q.delete();
        wr_cyc_q.delete();
        wr_dat_q.delete();
        start_cyc_q.delete();
    endtask

    task automatic feed(input int n, input bit full_rate, input bit chk_stall);
        int k = 0;
        int budget = 0;
        bit exp_stall = 0;
        bit exp_resume = 0;
        while (k < n && budget < 8 * n + 200) begin
            @(negedge clk);
            budget++;
            if (exp_stall) begin
                check("in_ready_stall", in_ready, 1'b0);
                exp_stall = 0;
                exp_resume = 1;
            end else if (exp_resume) begin
                check("in_ready_resume", in_ready, 1'b1);
                exp_resume = 0;
            end
            in_valid  = full_rate ? 1'b1 : ($urandom_range(0, 3) != 0);
            in_sample = stim[k];
            if (in_valid && in_ready) begin
                k++;
                if (chk_stall && (k % 32 == 0)) exp_stall = 1;
            end
        end
        check("feed_count", k, n);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_frame(input bit pattern, input bit full_rate, input bit toggle, input int done_delay);
        int waited;
        int n;
        logic [511:0] exp_line;
        logic [511:0] tmp;
        logic [15:0] exp_s;
        bit prev_stall;
        logic [15:0] prev_s;
        logic prev_l;

        clear_logs();
        for (int i = 0; i < 2048; i++)
            stim[i] = pattern ? 16'((i / 32) * 16 + (i % 32)) : 16'($urandom);
        feed(2048, full_rate, full_rate);

        waited = 0;
        while (start_cyc_q.size() == 0 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("start_count", start_cyc_q.size(), 1);
        check("wr_count", wr_idx_q.size(), 64);
        for (int l = 0; l < 64 && l < wr_idx_q.size(); l++) begin
            for (int s = 0; s < 32; s++) exp_line[16*s +: 16] = stim[32*l + s];
            check("wr_index", wr_idx_q[l], l);
            check("wr_line", wr_dat_q[l], exp_line);
        end
        if (pattern && wr_dat_q.size() > 5) begin
            tmp = wr_dat_q[5];
            check("line5_slot3", tmp[63:48], 16'h0053);
        end
        if (start_cyc_q.size() > 0 && wr_cyc_q.size() == 64)
            check("start_after_last_wr", start_cyc_q[0] - wr_cyc_q[63], 1);

        if (done_delay < 0) begin
            waited = 0;
            while (timeout_err !== 1'b1 && waited < 20000) begin
                @(negedge clk);
                waited++;
            end
            check("timeout_latency", cyc - start_cyc_q[0], T_OUT);
            check("timeout_to_fill", busy, 1'b0);
            check("timeout_no_output", out_valid, 1'b0);
            return;
        end

        repeat (done_delay) @(negedge clk);
        ap_done = 1'b1;
        @(negedge clk);
        ap_done = 1'b0;

        n = 0;
        waited = 0;
        prev_stall = 0;
        prev_s = '0;
        prev_l = 1'b0;
        while (n < 2048 && waited < 20000) begin
            @(negedge clk);
            waited++;
            out_ready = toggle ? ~out_ready : 1'b1;
            if (prev_stall) begin
                check("hold_valid", out_valid, 1'b1);
                check("hold_sample", out_sample, prev_s);
                check("hold_last", out_last, prev_l);
            end
            prev_stall = out_valid && !out_ready;
            prev_s = out_sample;
            prev_l = out_last;
            if (out_valid && out_ready) begin
                exp_s = ~stim[n];
                check("out_sample", out_sample, exp_s);
                check("out_last", out_last, (n == 2047));
                n++;
            end
        end
        check("out_count", n, 2048);
        @(negedge clk);
        check("frame_end_idle", {busy, out_valid}, 2'b00);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_ctrl", {in_ready, out_valid, out_last, ap_data_wr_en, ap_start, busy, timeout_err}, 7'b0);
        check("rst_idx", {ap_input_index, ap_output_index}, 12'b0);
        check("rst_data", ap_data_in, '0);
        check("rst_sample", out_sample, 16'h0000);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", in_ready, 1'b1);
        check("busy_after_rst", busy, 1'b0);

        // Counting pattern, full-rate input, always-ready output.
        do_frame(1'b1, 1'b1, 1'b0, 100);
        // Random data, bursty input, output ready toggling.
        do_frame(1'b0, 1'b0, 1'b1, int'($urandom_range(1, 30)));
        // AudioProcessor never finishes.
        do_frame(1'b0, 1'b1, 1'b0, -1);
        // Normal frame after a timeout.
        do_frame(1'b0, 1'b0, 1'b0, 20);
        check("timeout_sticky", timeout_err, 1'b1);

        // Reset part-way into the second line.
        clear_logs();
        for (int i = 0; i < 2048; i++) stim[i] = 16'($urandom);
        feed(40, 1'b0, 1'b0);
        check("pre_rst_writes", wr_idx_q.size(), 1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_outs", {in_ready, busy, ap_data_wr_en, ap_start}, 4'b0);
        rst = 1'b0;
        @(negedge clk);
        check("err_cleared_by_rst", timeout_err, 1'b0);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            ap_done = (c == 5);
            check("fill_ignores_done", {busy, out_valid}, 2'b00);
            check("fill_no_rd_index", ap_output_index, 6'd0);
        end
        ap_done = 1'b0;
        check("post_rst_writes", wr_idx_q.size(), 1);
        do_frame(1'b0, 1'b1, 1'b1, 50);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/audio_frame_loader.md
Name: audio_frame_loader

Overview:
- Streaming front/back end for AudioProcessor.
- Accepts 16-bit PCM samples on a valid/ready stream and packs 32 samples into each 512-bit line. Writes 64 lines (one 2048-sample frame) via data_wr_en/input_index, then pulses start.
- After done, reads the 64 processed lines back via output_index and re-serialises them onto an output valid/ready stream.
- Sits between the host sample FIFO and AudioProcessor.

Parameters:
- SAMPLE_W, 16, bits per sample.
- SAMPLES_PER_LINE, 32, samples packed per bus line (bus width = SAMPLE_W*SAMPLES_PER_LINE = 512).
- LINES, 64, lines per frame (index width 6).
- RD_LATENCY, 1, cycles from ap_output_index change to valid ap_data_out.
- DONE_TIMEOUT, 16384, max cycles waited for ap_done.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- in_sample  in  16  input sample (signed PCM).
- in_valid  in  1  input sample valid.
- in_ready  out  1  loader can accept a sample.
- out_sample  out  16  processed sample.
- out_valid  out  1  out_sample valid.
- out_ready  in  1  downstream accepts out_sample.
- out_last  out  1  high with sample 2047 of a frame.
- ap_data_wr_en  out  1  line write strobe to AudioProcessor.
- ap_input_index  out  6  line index being written.
- ap_data_in  out  512  packed line.
- ap_start  out  1  one-cycle start pulse.
- ap_done  in  1  processing complete.
- ap_output_index  out  6  line index being read.
- ap_data_out  in  512  processed line.
- busy  out  1  high in any state except FILL.
- timeout_err  out  1  sticky; set when DONE_TIMEOUT expires.

Behaviour:
- Reset values:
  - All outputs 0.
  - State FILL; in_ready=1 on the first cycle after reset deasserts.
  - Sample and line counters 0; timeout_err cleared only by rst.
- Packing: sample k of a line occupies bits [16k+15:16k]; sample 0 is at the LSBs.
- Handshake: a transfer occurs only on a cycle with valid & ready high. out_sample, out_valid and out_last are held stable while out_valid=1 and out_ready=0.
- FILL:
  - in_ready=1; each accepted sample is shifted into line slot sample_cnt.
  - On acceptance of slot 31 go to WRITE; in_ready=0 in WRITE.
- WRITE (1 cycle):
  - ap_data_wr_en=1, ap_input_index=line_cnt, ap_data_in=packed line. line_cnt increments.
  - If line_cnt was 63, go to START; else return to FILL.
  - Back-to-back input therefore sees 1 stall cycle per 32 samples.
- START (1 cycle): ap_start=1; load timeout counter; go to WAIT_DONE.
- WAIT_DONE:
  - On ap_done=1 go to READ with line_cnt=0.
  - If the counter reaches DONE_TIMEOUT first, set timeout_err and return to FILL with counters cleared; the frame is dropped.
  - ap_done is ignored in every other state.
- READ:
  - Drive ap_output_index=line_cnt and wait RD_LATENCY cycles.
  - Capture ap_data_out into the output shift register, then go to DRAIN.
  - ap_output_index is held through DRAIN.
- DRAIN:
  - out_valid=1; out_sample = slot sample_cnt of the captured line, sample 0 first.
  - On each transfer sample_cnt increments.
  - On the transfer of slot 31: if line_cnt=63, go to FILL and clear counters; else increment line_cnt and go to READ.
  - out_last=1 only for slot 31 of line 63.
- No overlap: input is not accepted during WRITE, START, WAIT_DONE, READ or DRAIN. in_valid samples presented then are held by the upstream producer, not lost.
- Reset mid-operation (any state): return to FILL, discard the partial line, no further ap_* strobes. AudioProcessor is reset separately.
- in_valid while in_ready=0 has no effect. out_ready high while out_valid=0 has no effect.

Decomposition:
- Shared package audio_pkg:
  - SAMPLE_W, SAMPLES_PER_LINE, LINES, BUS_W=512.
  - Typedef sample_t (logic signed [15:0]).
  - Typedef line_t (logic [511:0]).
  - Typedef loader_state_e {FILL, WRITE, START, WAIT_DONE, READ, DRAIN}.
- One natural sub-module: line_serdes. It holds the 512-bit register, the 5-bit slot counter, and the parallel-load / serial-in / serial-out modes, and is shared by the FILL and DRAIN paths.

Test Plan:
- Stream 2048 samples of value 16*line+slot, in_valid held high -> exactly 64 ap_data_wr_en pulses with indices 0..63. Line 5 has sample 3 = 0x0053 at bits [63:48]. in_ready is low 1 cycle after every 32nd sample; one ap_start appears 1 cycle after index 63.
- Model returns ap_done 100 cycles after start with ap_data_out = ~line (lines indexed by ap_output_index) -> 2048 output samples, each equal to the bitwise inverse of its input, in order. out_last is high only on the 2048th sample.
- Downstream out_ready toggles 1/0 every cycle -> every sample is delivered once. out_sample does not change while out_valid=1 and out_ready=0.
- ap_done never asserted -> timeout_err=1 exactly DONE_TIMEOUT cycles after ap_start and state returns to FILL. A following frame completes normally with timeout_err still 1.
- rst pulsed after 40 input samples -> no further ap_data_wr_en. The next 2048 samples produce line 0 with indices restarting at 0, and the first sample is at bits [15:0].
- ap_done pulsed during FILL -> ignored; no READ and no ap_output_index activity until the frame is written and started.
